// File: rtl/nios_mul_seq_accum.sv
// nios_mul_seq_accum: sequencer/accumulator for the digit-serial multiplier cell.
// Latches two DATA_W operands and feeds the cell one DIGIT_W multiplier digit
// per cycle. Each partial product comes back from the cell one cycle later and
// is shifted into place and added to the low DATA_W bits of the product.
// Optional build macro MUL_SEQ_EARLY_EXIT_EN: only the digits up to the highest
// nonzero digit of src2 are issued, which shortens the latency. The result
// value is the same in both builds.
module nios_mul_seq_accum #(
   parameter int DATA_W  = 32,
   parameter int DIGIT_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   input  logic              kill,
   output logic              ready,
   output logic              result_valid,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] cell_src1,
   output logic [DATA_W-1:0] cell_src2,
   input  logic [DATA_W-1:0] cell_result
);

   localparam int NUM_DIG = DATA_W / DIGIT_W;
   localparam int CNT_W   = $clog2(NUM_DIG + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t              state_reg;
   logic [DATA_W-1:0]   a_reg;
   logic [DATA_W-1:0]   b_reg;
   logic [DATA_W-1:0]   acc_reg;
   logic [DATA_W-1:0]   result_reg;
   logic [CNT_W-1:0]    k_reg;
   logic [CNT_W-1:0]    n_reg;
   logic [CNT_W-1:0]    pend_idx_reg;
   logic                pend_reg;

   logic [CNT_W-1:0]    n_accept;
   logic [DIGIT_W-1:0]  cur_digit;
   logic [DATA_W-1:0]   acc_sum;

`ifdef MUL_SEQ_EARLY_EXIT_EN
   logic [NUM_DIG-1:0]  digit_nz;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIG; gi++) begin : g_digit_nz
         assign digit_nz[gi] = |src2[gi*DIGIT_W +: DIGIT_W];
      end
   endgenerate

   // Digit count to issue: one past the highest nonzero digit, at least one.
   always_comb begin
      n_accept = CNT_W'(1);
      for (int i = 0; i < NUM_DIG; i++) begin
         if (digit_nz[i]) begin
            n_accept = CNT_W'(i + 1);
         end
      end
   end
`else
   assign n_accept = CNT_W'(NUM_DIG);
`endif

   assign cur_digit = b_reg[DIGIT_W*k_reg +: DIGIT_W];

   // Running sum including the partial product that arrives this cycle.
   always_comb begin
      acc_sum = acc_reg;
      if (pend_reg) begin
         acc_sum = acc_reg + (cell_result << (DIGIT_W * pend_idx_reg));
      end
   end

   // Sequencer state, operand latches and accumulator.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         a_reg        <= '0;
         b_reg        <= '0;
         acc_reg      <= '0;
         result_reg   <= '0;
         k_reg        <= '0;
         n_reg        <= '0;
         pend_idx_reg <= '0;
         pend_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               // DONE also accepts so ops can run back to back.
               if (start) begin
                  a_reg     <= src1;
                  b_reg     <= src2;
                  acc_reg   <= '0;
                  k_reg     <= '0;
                  pend_reg  <= 1'b0;
                  n_reg     <= n_accept;
                  state_reg <= ISSUE;
               end else begin
                  state_reg <= IDLE;
               end
            end
            ISSUE: begin
               if (kill) begin
                  acc_reg   <= '0;
                  pend_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  acc_reg      <= acc_sum;
                  pend_reg     <= 1'b1;
                  pend_idx_reg <= k_reg;
                  if (k_reg == n_reg - CNT_W'(1)) begin
                     state_reg <= DRAIN;
                  end else begin
                     k_reg <= k_reg + CNT_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (kill) begin
                  acc_reg   <= '0;
                  pend_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else begin
                  // Last partial product lands here; publish the total.
                  acc_reg    <= acc_sum;
                  result_reg <= acc_sum;
                  pend_reg   <= 1'b0;
                  state_reg  <= DONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ready        = (state_reg == IDLE) || (state_reg == DONE);
   assign result_valid = (state_reg == DONE);
   assign result       = result_reg;
   assign cell_src1    = ((state_reg == ISSUE) || (state_reg == DRAIN)) ? a_reg : '0;
   assign cell_src2    = (state_reg == ISSUE) ? DATA_W'(cur_digit) : '0;

endmodule

// File: tb/tb_nios_mul_seq_accum.sv
// Bench for nios_mul_seq_accum with a behavioural 1-cycle-latency multiplier
// cell. Expected products come from plain 64-bit multiplication; expected
// latency comes from the digit count of src2. Latency is measured as edges
// after the accept edge until the DONE cycle begins (n+1 edges, so n+2 edges
// counting the accept edge itself).
module tb_nios_mul_seq_accum;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [DW-1:0] src1;
   logic [DW-1:0] src2;
   logic          kill;
   logic          ready;
   logic          result_valid;
   logic [DW-1:0] result;
   logic [DW-1:0] cell_src1;
   logic [DW-1:0] cell_src2;
   logic [DW-1:0] cell_result;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] last_res = '0;

   always #5 clk = ~clk;

   nios_mul_seq_accum dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .src1         (src1),
      .src2         (src2),
      .kill         (kill),
      .ready        (ready),
      .result_valid (result_valid),
      .result       (result),
      .cell_src1    (cell_src1),
      .cell_src2    (cell_src2),
      .cell_result  (cell_result)
   );

   // Behavioural multiplier cell: registered product, shares the reset.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cell_result <= '0;
      else          cell_result <= cell_src1 * cell_src2;
   end

   function automatic logic [DW-1:0] model_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [63:0] p;
      p = {32'd0, a} * {32'd0, b};
      return p[DW-1:0];
   endfunction

   // Edges from accept to the start of the DONE cycle.
   function automatic int model_edges(input logic [DW-1:0] b);
      int n;
`ifdef MUL_SEQ_EARLY_EXIT_EN
      n = 1;
      for (int d = 1; d < 8; d++) if ((b >> (4 * d)) != 0) n = d + 1;
`else
      n = 8;
`endif
      return n + 1;
   endfunction

   // Called just after a negedge: requests an op, returns after the accept edge.
   task automatic launch(input logic [DW-1:0] a, input logic [DW-1:0] b);
      start = 1'b1;
      src1  = a;
      src2  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts edges until result_valid; bounded so a stuck DUT still terminates.
   task automatic wait_valid(output int edges, output logic [DW-1:0] res);
      edges = 0;
      while (result_valid !== 1'b1 && edges < 60) begin
         @(negedge clk);
         edges++;
      end
      res = result;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; kill = 1'b0; src1 = '0; src2 = '0;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
      total++; if (result !== '0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
      total++; if (cell_src1 !== '0) begin bad++; $display("FAIL reset_cell_src1 got=%h exp=0", cell_src1); end
      total++; if (cell_src2 !== '0) begin bad++; $display("FAIL reset_cell_src2 got=%h exp=0", cell_src2); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      $display("reset: ready=%b valid=%b result=%h", ready, result_valid, result);
   endtask

   task automatic test_directed();
      logic [DW-1:0] av [4] = '{32'd3, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0001_0000};
      logic [DW-1:0] bv [4] = '{32'd5, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0001_0000};
      logic [DW-1:0] ev [4] = '{32'd15, 32'h0000_0001, 32'h2345_6780, 32'h0000_0000};
      int edges;
      logic [DW-1:0] res;
      for (int i = 0; i < 4; i++) begin
         launch(av[i], bv[i]);
         wait_valid(edges, res);
         total++; if (res !== ev[i]) begin bad++; $display("FAIL dir_result[%0d] got=%h exp=%h", i, res, ev[i]); end
         total++; if (edges != model_edges(bv[i])) begin bad++; $display("FAIL dir_latency[%0d] got=%0d exp=%0d", i, edges, model_edges(bv[i])); end
         last_res = ev[i];
         @(negedge clk);
         total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL dir_pulse[%0d] got=%b exp=0", i, result_valid); end
         total++; if (result !== ev[i]) begin bad++; $display("FAIL dir_hold[%0d] got=%h exp=%h", i, result, ev[i]); end
         $display("directed %0d: %h*%h -> %h edges=%0d", i, av[i], bv[i], res, edges);
      end
   endtask

   task automatic test_random();
      int edges;
      logic [DW-1:0] a, b, res, exp;
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         exp = model_prod(a, b);
         launch(a, b);
         wait_valid(edges, res);
         total++; if (res !== exp) begin bad++; $display("FAIL rnd_result[%0d] got=%h exp=%h", i, res, exp); end
         total++; if (edges != model_edges(b)) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, edges, model_edges(b)); end
         last_res = exp;
         @(negedge clk);
         $display("random %0d: %h*%h -> %h edges=%0d", i, a, b, res, edges);
      end
   endtask

   task automatic test_start_ignored();
      int edges;
      logic [DW-1:0] res;
      launch(32'hDEAD_BEEF, 32'h0000_00A7);
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL busy_ready got=%b exp=0", ready); end
      total++; if (cell_src1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL busy_cell_src1 got=%h exp=deadbeef", cell_src1); end
      total++; if (cell_src2 !== 32'h7) begin bad++; $display("FAIL busy_cell_src2 got=%h exp=7", cell_src2); end
      // A second request held while busy must not disturb the running op.
      start = 1'b1; src1 = 32'h1111_1111; src2 = 32'h2222_2222;
      @(negedge clk);
      start = 1'b0;
      wait_valid(edges, res);
      total++; if (res !== model_prod(32'hDEAD_BEEF, 32'hA7)) begin bad++; $display("FAIL ignore_result got=%h exp=%h", res, model_prod(32'hDEAD_BEEF, 32'hA7)); end
      last_res = model_prod(32'hDEAD_BEEF, 32'hA7);
      @(negedge clk);
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL ignore_no_second got=%b exp=0", result_valid); end
      $display("start_ignored: result=%h", res);
   endtask

   task automatic test_back_to_back();
      int edges;
      logic [DW-1:0] res;
      launch(32'd3, 32'd5);
      wait_valid(edges, res);
      total++; if (res !== 32'd15) begin bad++; $display("FAIL b2b_first got=%h exp=f", res); end
      // Still in the DONE cycle: request the next op right away.
      launch(32'd7, 32'd9);
      wait_valid(edges, res);
      total++; if (res !== 32'd63) begin bad++; $display("FAIL b2b_second got=%0d exp=63", res); end
      total++; if (edges != model_edges(32'd9)) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", edges, model_edges(32'd9)); end
      last_res = 32'd63;
      @(negedge clk);
      $display("back_to_back: second=%0d edges=%0d", res, edges);
   endtask

   task automatic test_kill();
      int edges, pulses, kill_at;
      logic [DW-1:0] res;
      // Abort on the 4th ISSUE cycle, or in DRAIN when the op is shorter.
      kill_at = model_edges(32'd5);
      if (kill_at > 4) kill_at = 4;
      launch(32'd3, 32'd5);
      repeat (kill_at - 1) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL kill_ready got=%b exp=1", ready); end
      total++; if (result !== last_res) begin bad++; $display("FAIL kill_result got=%h exp=%h", result, last_res); end
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (result_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL kill_no_valid got=%0d exp=0", pulses); end
      launch(32'd2, 32'd2);
      wait_valid(edges, res);
      total++; if (res !== 32'd4) begin bad++; $display("FAIL kill_after got=%0d exp=4", res); end
      last_res = 32'd4;
      @(negedge clk);
      $display("kill: pulses=%0d after=%0d", pulses, res);
   endtask

   task automatic test_reset_mid();
      int edges;
      logic [DW-1:0] res;
      launch(32'h0BAD_F00D, 32'h0000_0003);
      // First ISSUE cycle is already underway; step to the DRAIN cycle.
      repeat (model_edges(32'h3) - 1) @(negedge clk);
      total++; if (cell_src1 !== 32'h0BAD_F00D) begin bad++; $display("FAIL drain_cell_src1 got=%h exp=0badf00d", cell_src1); end
      #2 reset_n = 1'b0;
      #1;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", ready); end
      total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", result_valid); end
      total++; if (result !== '0) begin bad++; $display("FAIL rmid_result got=%h exp=0", result); end
      total++; if (cell_src1 !== '0) begin bad++; $display("FAIL rmid_cell_src1 got=%h exp=0", cell_src1); end
      last_res = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      launch(32'd6, 32'd7);
      wait_valid(edges, res);
      total++; if (res !== 32'd42) begin bad++; $display("FAIL rmid_after got=%0d exp=42", res); end
      total++; if (edges != model_edges(32'd7)) begin bad++; $display("FAIL rmid_latency got=%0d exp=%0d", edges, model_edges(32'd7)); end
      @(negedge clk);
      $display("reset_mid: after=%0d edges=%0d", res, edges);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nios_mul_seq_accum.md
Name: nios_mul_seq_accum

Overview:
- Multi-cycle sequencer and accumulator for the CPU's digit-serial multiplier cell, one stage downstream of it.
- Latches 32-bit operands and feeds the cell one multiplier digit per cycle (full src1, src2 digit in bits [DIGIT_W-1:0]).
- Consumes the cell's registered 1-cycle-latency partial products; shifts and accumulates them into the low DATA_W bits of src1*src2.
- Low word is identical for signed and unsigned operands; no sign handling.

Parameters:
DATA_W  32  operand/result width
DIGIT_W  4  multiplier digit width; must divide DATA_W (NUM_DIG = DATA_W/DIGIT_W, derived, 8 by default)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  operation request, accepted when start && ready
src1  in  DATA_W  multiplicand, sampled on accept
src2  in  DATA_W  multiplier, sampled on accept
kill  in  1  synchronous abort
ready  out  1  can accept start
result_valid  out  1  one-cycle pulse, result valid
result  out  DATA_W  (src1*src2) mod 2^DATA_W
cell_src1  out  DATA_W  to cell multiplicand
cell_src2  out  DATA_W  to cell multiplier; digit in [DIGIT_W-1:0], upper bits 0
cell_result  in  DATA_W  from cell; product of the operands driven on the previous cycle

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; acc, result, the operand registers, digit index k, pend and pend_idx all 0.
  - ready=1, result_valid=0, cell_src1=0, cell_src2=0.
- States: IDLE, ISSUE, DRAIN, DONE.
- ready=1 in IDLE and DONE, 0 in ISSUE and DRAIN. start while ready=0 is ignored, with no queuing.
- Accept edge (start && ready):
  - latch A=src1 and B=src2; acc<=0, k<=0, pend<=0, n<=NUM_DIG.
  - go to ISSUE.
- ISSUE, digit k:
  - cell_src1=A and cell_src2={0, B[DIGIT_W*k +: DIGIT_W]}.
  - At each edge: pend<=1 and pend_idx<=k. If k==n-1, go to DRAIN; else k<=k+1.
- Accumulate, at every edge in ISSUE or DRAIN with pend=1:
  - acc<=acc+(cell_result<<(DIGIT_W*pend_idx)), truncated to DATA_W.
  - Carries above DATA_W are discarded.
- DRAIN:
  - cell_src1=A and cell_src2=0.
  - At the edge: final accumulate, result<=acc+shifted term, go to DONE.
- DONE:
  - result_valid=1 for exactly one cycle.
  - result holds until the next DONE or reset.
  - Next edge goes to IDLE, or to ISSUE if start is sampled (back-to-back; result_valid still pulses that cycle).
- Latency: result_valid is high in the cycle beginning n+2 edges after the accept edge (10 by default). Throughput: one op per n+2 cycles.
- cell_src1/cell_src2 are 0 in IDLE and DONE.
- kill:
  - Sampled in ISSUE or DRAIN: next state IDLE, acc and pend cleared, no result_valid, result unchanged.
  - kill has priority over start.
  - Ignored in IDLE and DONE.
- Reset mid-operation: immediate return to reset values, no result_valid. The cell clears from the same reset.
- Wrap: product bits at and above DATA_W are dropped, e.g. 0x00010000*0x00010000 -> 0.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- Defined:
  - On accept, n = 1 + index of the highest nonzero digit of src2; n=1 if src2==0.
  - Only digits 0..n-1 are issued; latency is n+2, e.g. 3 for src2 < 2^DIGIT_W.
- Undefined: n=NUM_DIG always, giving fixed latency NUM_DIG+2.
- The result value is identical in both builds.

Test Plan:
- Bench includes a behavioural 1-cycle-latency cell model.
- start with src1=3, src2=5 -> result=15, result_valid 10 edges after accept (3 if EN).
- src1=0xFFFFFFFF, src2=0xFFFFFFFF -> result=0x00000001, latency 10 in both builds.
- src1=0x12345678, src2=0x10 -> result=0x23456780; src1=0x00010000, src2=0x00010000 -> result=0x00000000.
- Back-to-back: second start (7*9) asserted in the DONE cycle of the first op -> first result_valid pulses, second result=63 after 10 more edges. start held during ISSUE is ignored.
- kill at the 4th ISSUE cycle of 3*5 -> no result_valid, ready=1 next cycle, result keeps its previous value. A following 2*2 returns 4.
- reset_n pulled low mid-DRAIN -> outputs 0 and ready=1 asynchronously. After release, 6*7 returns 42.
